// File: rtl/sram_ecc_pkg.sv
// sram_ecc_pkg: shared constants, Hamming masks, SECDED encoder and controller state type.
// Codeword layout: [31:0] data, [37:32] Hamming check bits, [38] overall parity.
// The SCRUB state exists only when SRAM_ECC_SCRUB_EN is defined.
package sram_ecc_pkg;

   localparam int unsigned AW = 14;
   localparam int unsigned DW = 32;
   localparam int unsigned CW = DW + 7;

   // Hamming position (1..38, skipping powers of two) assigned to data bit idx.
   function automatic logic [5:0] ham_pos(input int unsigned idx);
      int unsigned cnt;
      logic [5:0]  pos;
      cnt = 0;
      pos = '0;
      for (int unsigned p = 1; p < 39; p++) begin
         if ((p & (p - 1)) != 0) begin
            if (cnt == idx) pos = 6'(p);
            cnt++;
         end
      end
      return pos;
   endfunction

   // Data bits covered by check bit j: those whose Hamming position has bit j set.
   function automatic logic [DW-1:0] ham_mask(input int unsigned j);
      logic [DW-1:0] m;
      logic [5:0]    pos;
      m = '0;
      for (int unsigned i = 0; i < DW; i++) begin
         pos = ham_pos(i) >> j;
         m   = {pos[0], m[DW-1:1]};
      end
      return m;
   endfunction

   localparam logic [DW-1:0] HamMask0 = ham_mask(0);
   localparam logic [DW-1:0] HamMask1 = ham_mask(1);
   localparam logic [DW-1:0] HamMask2 = ham_mask(2);
   localparam logic [DW-1:0] HamMask3 = ham_mask(3);
   localparam logic [DW-1:0] HamMask4 = ham_mask(4);
   localparam logic [DW-1:0] HamMask5 = ham_mask(5);

   function automatic logic [CW-1:0] ecc_encode(input logic [DW-1:0] d);
      logic [5:0] c;
      c[0] = ^(d & HamMask0);
      c[1] = ^(d & HamMask1);
      c[2] = ^(d & HamMask2);
      c[3] = ^(d & HamMask3);
      c[4] = ^(d & HamMask4);
      c[5] = ^(d & HamMask5);
      return {^{c, d}, c, d};
   endfunction

`ifdef SRAM_ECC_SCRUB_EN
   typedef enum logic [1:0] {StIdle, StRmw, StScrub} state_e;
`else
   typedef enum logic [0:0] {StIdle, StRmw} state_e;
`endif

endpackage

// File: rtl/sram_secded_dec.sv
// sram_secded_dec: combinational SECDED decoder for one 39-bit codeword.
module sram_secded_dec
   import sram_ecc_pkg::*;
(
   input  logic [CW-1:0] cw_i,
   output logic [DW-1:0] data_o,
   output logic          sbe_o,
   output logic          dbe_o
);

   logic [5:0]    syn;
   logic          par_err;
   logic [DW-1:0] flip;

   // One flip line per data bit, hit when the syndrome names that bit's position.
   for (genvar gi = 0; gi < DW; gi++) begin : g_flip
      assign flip[gi] = (syn == ham_pos(gi));
   end

   // Syndrome/parity decode; check-bit or parity-bit errors leave data untouched.
   always_comb begin
      syn[0]  = ^(cw_i[DW-1:0] & HamMask0) ^ cw_i[DW+0];
      syn[1]  = ^(cw_i[DW-1:0] & HamMask1) ^ cw_i[DW+1];
      syn[2]  = ^(cw_i[DW-1:0] & HamMask2) ^ cw_i[DW+2];
      syn[3]  = ^(cw_i[DW-1:0] & HamMask3) ^ cw_i[DW+3];
      syn[4]  = ^(cw_i[DW-1:0] & HamMask4) ^ cw_i[DW+4];
      syn[5]  = ^(cw_i[DW-1:0] & HamMask5) ^ cw_i[DW+5];
      par_err = ^cw_i;
      sbe_o   = par_err;
      dbe_o   = ~par_err & (syn != 6'd0);
      data_o  = cw_i[DW-1:0] ^ (par_err ? flip : '0);
   end

endmodule

// File: rtl/sram_ecc_ctrl.sv
// sram_ecc_ctrl: SECDED request controller in front of a 16384x39 single-port SRAM.
// Reads return in 2 cycles; partial writes take a read-modify-write cycle.
// Define SRAM_ECC_SCRUB_EN to write corrected words back after a single-bit read error.
module sram_ecc_ctrl
   import sram_ecc_pkg::*;
(
   input  logic          CLK,
   input  logic          RST_N,
   input  logic          REQ_VALID,
   output logic          REQ_READY,
   input  logic          REQ_WE,
   input  logic [3:0]    REQ_BE,
   input  logic [AW-1:0] REQ_ADR,
   input  logic [DW-1:0] REQ_WDATA,
   output logic          RSP_VALID,
   output logic [DW-1:0] RSP_RDATA,
   output logic          RSP_SBE,
   output logic          RSP_DBE,
   output logic          WR_ERR,
   output logic [AW-1:0] MEM_ADR,
   output logic [CW-1:0] MEM_D,
   output logic          MEM_WE,
   input  logic [CW-1:0] MEM_Q
);

   state_e        state_q, state_d;
   logic          rdy_q;
   logic          rd_pend_q, rd_pend_d;
   logic [AW-1:0] adr_q, adr_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic [3:0]    be_q, be_d;
   logic          rsp_valid_q, rsp_valid_d;
   logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
   logic          rsp_sbe_q, rsp_sbe_d;
   logic          rsp_dbe_q, rsp_dbe_d;
   logic          wr_err_q, wr_err_d;
`ifdef SRAM_ECC_SCRUB_EN
   logic          scrub_pend_q, scrub_pend_d;
   logic [AW-1:0] scrub_adr_q, scrub_adr_d;
   logic [DW-1:0] scrub_data_q, scrub_data_d;
   logic [AW-1:0] rd_adr_q, rd_adr_d;
`endif

   logic          req_rdy, acc_rd, acc_full, acc_part, acc_wr_nz;
   logic [DW-1:0] dec_data, be_mask, merged;
   logic          dec_sbe, dec_dbe;

   sram_secded_dec u_dec (
      .cw_i   (MEM_Q),
      .data_o (dec_data),
      .sbe_o  (dec_sbe),
      .dbe_o  (dec_dbe)
   );

   // rdy_q keeps REQ_READY low while in reset and releases it one edge later.
   assign req_rdy   = rdy_q & (state_q == StIdle);
   assign acc_rd    = REQ_VALID & req_rdy & ~REQ_WE;
   assign acc_wr_nz = REQ_VALID & req_rdy & REQ_WE & (REQ_BE != 4'h0);
   assign acc_full  = acc_wr_nz & (REQ_BE == 4'hF);
   assign acc_part  = acc_wr_nz & (REQ_BE != 4'hF);
   assign be_mask   = {{8{be_q[3]}}, {8{be_q[2]}}, {8{be_q[1]}}, {8{be_q[0]}}};
   assign merged    = (wdata_q & be_mask) | (dec_data & ~be_mask);

   // State register.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) state_q <= StIdle;
      else        state_q <= state_d;
   end

   // Next state: partial writes detour through RMW; a pending scrub claims the next idle slot.
   always_comb begin
      state_d = StIdle;
      case (state_q)
         StIdle:  state_d = acc_part ? StRmw : StIdle;
         StRmw:   state_d = StIdle;
         default: state_d = StIdle;
      endcase
`ifdef SRAM_ECC_SCRUB_EN
      if ((state_d == StIdle) && scrub_pend_d) state_d = StScrub;
`endif
   end

   // SRAM port and handshake outputs.
   always_comb begin
      REQ_READY = req_rdy;
      MEM_ADR   = REQ_ADR;
      MEM_D     = ecc_encode(REQ_WDATA);
      MEM_WE    = 1'b0;
      case (state_q)
         StIdle: MEM_WE = acc_full;
         StRmw: begin
            MEM_ADR = adr_q;
            MEM_D   = ecc_encode(merged);
            MEM_WE  = ~dec_dbe;
         end
`ifdef SRAM_ECC_SCRUB_EN
         StScrub: begin
            MEM_ADR = scrub_adr_q;
            MEM_D   = ecc_encode(scrub_data_q);
            MEM_WE  = 1'b1;
         end
`endif
         default: MEM_WE = 1'b0;
      endcase
   end

   // Datapath next values: response capture, RMW latch, write-error pulse, scrub buffer.
   always_comb begin
      rd_pend_d   = acc_rd;
      rsp_valid_d = rd_pend_q;
      rsp_rdata_d = rd_pend_q ? dec_data : rsp_rdata_q;
      rsp_sbe_d   = rd_pend_q ? dec_sbe  : rsp_sbe_q;
      rsp_dbe_d   = rd_pend_q ? dec_dbe  : rsp_dbe_q;
      wr_err_d    = (state_q == StRmw) & dec_dbe;
      adr_d       = acc_part ? REQ_ADR   : adr_q;
      wdata_d     = acc_part ? REQ_WDATA : wdata_q;
      be_d        = acc_part ? REQ_BE    : be_q;
`ifdef SRAM_ECC_SCRUB_EN
      rd_adr_d     = acc_rd ? REQ_ADR : rd_adr_q;
      scrub_pend_d = scrub_pend_q & (state_q != StScrub);
      scrub_adr_d  = scrub_adr_q;
      scrub_data_d = scrub_data_q;
      // Single buffer: a new SBE is taken only when nothing is pending.
      if (rd_pend_q && dec_sbe && !scrub_pend_q) begin
         scrub_pend_d = 1'b1;
         scrub_adr_d  = rd_adr_q;
         scrub_data_d = dec_data;
      end
      // A newer write to the same word makes the scrub data stale.
      if (acc_wr_nz && (REQ_ADR == scrub_adr_d)) scrub_pend_d = 1'b0;
`endif
   end

   // Datapath registers; reset drops any in-flight read or RMW.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         rdy_q        <= 1'b0;
         rd_pend_q    <= 1'b0;
         adr_q        <= '0;
         wdata_q      <= '0;
         be_q         <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_rdata_q  <= '0;
         rsp_sbe_q    <= 1'b0;
         rsp_dbe_q    <= 1'b0;
         wr_err_q     <= 1'b0;
`ifdef SRAM_ECC_SCRUB_EN
         scrub_pend_q <= 1'b0;
         scrub_adr_q  <= '0;
         scrub_data_q <= '0;
         rd_adr_q     <= '0;
`endif
      end else begin
         rdy_q        <= 1'b1;
         rd_pend_q    <= rd_pend_d;
         adr_q        <= adr_d;
         wdata_q      <= wdata_d;
         be_q         <= be_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_rdata_q  <= rsp_rdata_d;
         rsp_sbe_q    <= rsp_sbe_d;
         rsp_dbe_q    <= rsp_dbe_d;
         wr_err_q     <= wr_err_d;
`ifdef SRAM_ECC_SCRUB_EN
         scrub_pend_q <= scrub_pend_d;
         scrub_adr_q  <= scrub_adr_d;
         scrub_data_q <= scrub_data_d;
         rd_adr_q     <= rd_adr_d;
`endif
      end
   end

   assign RSP_VALID = rsp_valid_q;
   assign RSP_RDATA = rsp_rdata_q;
   assign RSP_SBE   = rsp_sbe_q;
   assign RSP_DBE   = rsp_dbe_q;
   assign WR_ERR    = wr_err_q;

endmodule

// File: tb/tb_sram_ecc_ctrl.sv
// tb_sram_ecc_ctrl: directed + random bench for sram_ecc_ctrl with a behavioural SRAM,
// a byte-level data model and a position-XOR reference encoder.
module tb_sram_ecc_ctrl;

   logic        CLK = 1'b0;
   logic        RST_N;
   logic        REQ_VALID, REQ_READY, REQ_WE;
   logic [3:0]  REQ_BE;
   logic [13:0] REQ_ADR;
   logic [31:0] REQ_WDATA;
   logic        RSP_VALID, RSP_SBE, RSP_DBE, WR_ERR;
   logic [31:0] RSP_RDATA;
   logic [13:0] MEM_ADR;
   logic [38:0] MEM_D;
   logic        MEM_WE;
   logic [38:0] q;

   sram_ecc_ctrl dut (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .REQ_VALID (REQ_VALID),
      .REQ_READY (REQ_READY),
      .REQ_WE    (REQ_WE),
      .REQ_BE    (REQ_BE),
      .REQ_ADR   (REQ_ADR),
      .REQ_WDATA (REQ_WDATA),
      .RSP_VALID (RSP_VALID),
      .RSP_RDATA (RSP_RDATA),
      .RSP_SBE   (RSP_SBE),
      .RSP_DBE   (RSP_DBE),
      .WR_ERR    (WR_ERR),
      .MEM_ADR   (MEM_ADR),
      .MEM_D     (MEM_D),
      .MEM_WE    (MEM_WE),
      .MEM_Q     (q)
   );

   always #5 CLK = ~CLK;

   // Behavioural SRAM with a backdoor bit-flip port.
   logic [38:0] mem [16384];
   logic        bd_en = 1'b0;
   logic [13:0] bd_adr = '0;
   logic [38:0] bd_mask = '0;
   int          we_cnt = 0;
   always @(posedge CLK) begin
      if (bd_en) mem[bd_adr] <= mem[bd_adr] ^ bd_mask;
      else if (MEM_WE) mem[MEM_ADR] <= MEM_D;
      if (MEM_WE) we_cnt <= we_cnt + 1;
      q <= mem[MEM_ADR];
   end

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   // Response / error-pulse monitor.
   logic [31:0] got_d [256];
   logic        got_s [256];
   logic        got_e [256];
   int          got_c [256];
   int          got_n = 0;
   int          wr_err_cnt = 0;
   always @(negedge CLK) begin
      if (RSP_VALID && got_n < 256) begin
         got_d[got_n] <= RSP_RDATA;
         got_s[got_n] <= RSP_SBE;
         got_e[got_n] <= RSP_DBE;
         got_c[got_n] <= cyc;
         got_n        <= got_n + 1;
      end
      if (WR_ERR) wr_err_cnt <= wr_err_cnt + 1;
   end

   logic [31:0] exp_d [256];
   logic        exp_s [256];
   logic        exp_e [256];
   int          exp_c [256];
   int          exp_n = 0;
   int          chk_ptr = 0;
   logic [31:0] ref_mem [16384];
   int          total = 0;
   int          bad = 0;

   // Codeword whose set bits XOR (by Hamming position) to zero, plus even overall parity.
   function automatic logic [38:0] ref_encode(input logic [31:0] d);
      logic [38:0] cw;
      int          syn, k;
      cw = '0;
      cw[31:0] = d;
      syn = 0;
      k = 0;
      for (int p = 1; p < 39; p++) begin
         if ((p & (p - 1)) != 0) begin
            if (d[k[4:0]]) syn = syn ^ p;
            k++;
         end
      end
      cw[37:32] = syn[5:0];
      cw[38]    = ^cw[37:0];
      return cw;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic op(input logic we, input logic [3:0] be, input logic [13:0] adr,
                     input logic [31:0] wd, output int acc_c);
      int n;
      n = 0;
      @(negedge CLK);
      REQ_VALID = 1'b1;
      REQ_WE    = we;
      REQ_BE    = be;
      REQ_ADR   = adr;
      REQ_WDATA = wd;
      #1;
      while (!REQ_READY && n < 20) begin
         @(negedge CLK);
         #1;
         n++;
      end
      chk("req_ready", 64'(REQ_READY), 64'd1);
      acc_c = cyc;
      @(posedge CLK);
      #1;
      REQ_VALID = 1'b0;
   endtask

   task automatic rd(input logic [13:0] adr, input logic [31:0] d, input logic s, input logic e);
      int c;
      op(1'b0, 4'h0, adr, 32'h0, c);
      exp_d[exp_n] = d;
      exp_s[exp_n] = s;
      exp_e[exp_n] = e;
      exp_c[exp_n] = c + 2;
      exp_n++;
   endtask

   task automatic wr(input logic [3:0] be, input logic [13:0] adr, input logic [31:0] wd);
      int c;
      op(1'b1, be, adr, wd, c);
      for (int b = 0; b < 4; b++)
         if (be[b]) ref_mem[adr][8*b +: 8] = wd[8*b +: 8];
   endtask

   task automatic bd_flip(input logic [13:0] adr, input logic [38:0] mask);
      @(negedge CLK);
      bd_adr  = adr;
      bd_mask = mask;
      bd_en   = 1'b1;
      @(posedge CLK);
      #1;
      bd_en = 1'b0;
   endtask

   task automatic drain();
      repeat (4) @(negedge CLK);
      chk("rsp_count", 64'(got_n), 64'(exp_n));
      for (int i = chk_ptr; i < exp_n; i++) begin
         if (i < got_n) begin
            chk("rsp_rdata", 64'(got_d[i]), 64'(exp_d[i]));
            chk("rsp_sbe", 64'(got_s[i]), 64'(exp_s[i]));
            chk("rsp_dbe", 64'(got_e[i]), 64'(exp_e[i]));
            chk("rsp_cycle", 64'(got_c[i]), 64'(exp_c[i]));
         end
      end
      chk_ptr = exp_n;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int          c, w0, e0, first;
      logic [38:0] pre;
      logic [31:0] v0;
      logic [13:0] a;

      RST_N = 1'b0;
      REQ_VALID = 1'b0;
      REQ_WE = 1'b0;
      REQ_BE = 4'h0;
      REQ_ADR = '0;
      REQ_WDATA = '0;
      repeat (2) @(negedge CLK);
      chk("rst_ready", 64'(REQ_READY), 64'd0);
      chk("rst_rsp_valid", 64'(RSP_VALID), 64'd0);
      chk("rst_rsp_rdata", 64'(RSP_RDATA), 64'd0);
      chk("rst_rsp_sbe", 64'(RSP_SBE), 64'd0);
      chk("rst_rsp_dbe", 64'(RSP_DBE), 64'd0);
      chk("rst_wr_err", 64'(WR_ERR), 64'd0);
      chk("rst_mem_we", 64'(MEM_WE), 64'd0);
      RST_N = 1'b1;
      repeat (2) @(negedge CLK);
      chk("ready_after_rst", 64'(REQ_READY), 64'd1);

      // Full write then clean read.
      wr(4'hF, 14'h0005, 32'hDEADBEEF);
      chk("stored_encode", 64'(mem[5]), 64'(ref_encode(32'hDEADBEEF)));
      rd(14'h0005, 32'hDEADBEEF, 1'b0, 1'b0);
      drain();

      // Single-bit error in data bit 7.
      bd_flip(14'h0005, 39'(1) << 7);
      rd(14'h0005, 32'hDEADBEEF, 1'b1, 1'b0);
      @(posedge CLK);
      @(posedge CLK);
      #1;
`ifdef SRAM_ECC_SCRUB_EN
      chk("scrub_writeback", 64'(mem[5]), 64'(ref_encode(32'hDEADBEEF)));
`else
      chk("no_scrub_word", 64'(mem[5]), 64'(ref_encode(32'hDEADBEEF) ^ (39'(1) << 7)));
`endif
      drain();

      // Double-bit error, then a partial write onto it is aborted.
      wr(4'hF, 14'h0005, 32'hDEADBEEF);
      bd_flip(14'h0005, (39'(1) << 3) | (39'(1) << 20));
      rd(14'h0005, 32'hDEADBEEF ^ 32'h0010_0008, 1'b0, 1'b1);
      drain();
      pre = mem[5];
      e0 = wr_err_cnt;
      w0 = we_cnt;
      op(1'b1, 4'b0001, 14'h0005, 32'h0000_0055, c);
      repeat (3) @(negedge CLK);
      chk("wr_err_pulse", 64'(wr_err_cnt), 64'(e0 + 1));
      chk("dbe_word_kept", 64'(mem[5]), 64'(pre));
      chk("dbe_no_write", 64'(we_cnt), 64'(w0));

      // Partial write merge; READY drops for exactly the RMW cycle.
      wr(4'hF, 14'h0009, 32'h11223344);
      wr(4'b0110, 14'h0009, 32'hAABBCCDD);
      @(negedge CLK);
      chk("rmw_ready_low", 64'(REQ_READY), 64'd0);
      @(negedge CLK);
      chk("rmw_ready_back", 64'(REQ_READY), 64'd1);
      rd(14'h0009, 32'h11BBCC44, 1'b0, 1'b0);
      drain();
      chk("rmw_stored", 64'(mem[9]), 64'(ref_encode(32'h11BBCC44)));

      // 16 back-to-back reads, then a BE=0 write inside a read stream.
      for (int i = 0; i < 16; i++) wr(4'hF, 14'(32 + i), $urandom);
      first = exp_n;
      for (int i = 0; i < 16; i++) rd(14'(32 + i), ref_mem[32 + i], 1'b0, 1'b0);
      chk("b2b_accepts", 64'(exp_c[first + 15] - exp_c[first]), 64'd15);
      drain();
      w0 = we_cnt;
      rd(14'd32, ref_mem[32], 1'b0, 1'b0);
      op(1'b1, 4'h0, 14'd33, 32'hFFFF_FFFF, c);
      rd(14'd34, ref_mem[34], 1'b0, 1'b0);
      rd(14'd33, ref_mem[33], 1'b0, 1'b0);
      drain();
      chk("be0_no_write", 64'(we_cnt), 64'(w0));

      // Reset during the RMW cycle drops the write.
      v0 = $urandom;
      wr(4'hF, 14'h0040, v0);
      w0 = we_cnt;
      op(1'b1, 4'b1100, 14'h0040, ~v0, c);
      RST_N = 1'b0;
      #1;
      chk("rmw_rst_mem_we", 64'(MEM_WE), 64'd0);
      chk("rmw_rst_ready", 64'(REQ_READY), 64'd0);
      chk("rmw_rst_rsp_valid", 64'(RSP_VALID), 64'd0);
      chk("rmw_rst_rdata", 64'(RSP_RDATA), 64'd0);
      chk("rmw_rst_wr_err", 64'(WR_ERR), 64'd0);
      repeat (2) @(negedge CLK);
      RST_N = 1'b1;
      repeat (2) @(negedge CLK);
      chk("rmw_rst_no_write", 64'(we_cnt), 64'(w0));
      rd(14'h0040, v0, 1'b0, 1'b0);
      drain();

      // Random mix of reads, full, partial and empty writes against the data model.
      for (int i = 0; i < 8; i++) wr(4'hF, 14'(256 + i), $urandom);
      for (int i = 0; i < 40; i++) begin
         a = 14'(256 + $urandom_range(0, 7));
         if ($urandom_range(0, 1) == 0) rd(a, ref_mem[a], 1'b0, 1'b0);
         else wr(4'($urandom_range(0, 15)), a, $urandom);
      end
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
